// File: rtl/fila_entrada.sv
// fila_entrada: synchronise/debounce enqueue and dequeue buttons and issue guarded one-cycle queue requests
// Ports: clk_10KHz, reset (async active-low), btn_enq/btn_deq raw buttons, sw_data raw switches,
//        len_in queue occupancy; enqueue_out/dequeue_out/drop_out one-cycle pulses, data_out latched
//        switch value, busy_out guard interval active.
module fila_entrada_db #(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic clk_10KHz,
  input  logic reset,
  input  logic btn,
  output logic acc
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, PRESS_WAIT = 3'd1, ACCEPT = 3'd2, HELD = 3'd3, RELEASE_WAIT = 3'd4;
  logic [1:0] s;
  logic [2:0] st, st_n;
  logic [DW-1:0] cnt, cnt_n, cnt_inc;
  logic sync, done;
  assign sync = s[1];
  assign done = cnt == DW'(DEBOUNCE_CYCLES);
  assign cnt_inc = done ? cnt : cnt + 1'b1;
  assign acc = st == ACCEPT;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    case (st)
      IDLE: if (sync) begin st_n = PRESS_WAIT; cnt_n = DW'(1); end
      PRESS_WAIT: begin
        st_n = !sync ? IDLE : done ? ACCEPT : PRESS_WAIT;
        cnt_n = (!sync || done) ? '0 : cnt_inc;
      end
      ACCEPT: st_n = HELD;
      HELD: if (!sync) begin st_n = RELEASE_WAIT; cnt_n = DW'(1); end
      RELEASE_WAIT: begin
        st_n = sync ? HELD : done ? IDLE : RELEASE_WAIT;
        cnt_n = (sync || done) ? '0 : cnt_inc;
      end
      default: begin st_n = IDLE; cnt_n = '0; end
    endcase
  end
  always_ff @(posedge clk_10KHz or negedge reset)
    if (!reset) begin
      s <= '0;
      st <= IDLE;
      cnt <= '0;
    end else begin
      s <= {s[0], btn};
      st <= st_n;
      cnt <= cnt_n;
    end
endmodule

module fila_entrada #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       btn_enq,
  input  logic       btn_deq,
  input  logic [7:0] sw_data,
  input  logic [3:0] len_in,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic       busy_out,
  output logic       drop_out
);
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  logic enq_acc, deq_acc, enq_pend, deq_pend, enq_req, deq_req, go, full, empty, pulse, guard_ok;
  logic [7:0] sw_s0, sw_s1;
  logic [GW-1:0] guard;
  fila_entrada_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enq (.clk_10KHz(clk_10KHz), .reset(reset), .btn(btn_enq), .acc(enq_acc));
  fila_entrada_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deq (.clk_10KHz(clk_10KHz), .reset(reset), .btn(btn_deq), .acc(deq_acc));
  // an ACCEPT counts as pending in its own cycle so the request issues on the following edge
  assign enq_req = enq_pend | enq_acc;
  assign deq_req = deq_pend | deq_acc;
  assign full = len_in >= 4'd8;
  assign empty = len_in == 4'd0;
  assign pulse = enqueue_out | dequeue_out | drop_out;
  assign busy_out = guard != '0;
  // the guard is loaded while a pulse is out, so the last guard cycle may already issue the next pulse
  assign guard_ok = (guard == GW'(0)) | (guard == GW'(1));
  assign go = !pulse && guard_ok && (enq_req || deq_req);
  always_ff @(posedge clk_10KHz or negedge reset)
    if (!reset) begin
      sw_s0 <= '0;
      sw_s1 <= '0;
      data_out <= '0;
      enq_pend <= 1'b0;
      deq_pend <= 1'b0;
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      drop_out <= 1'b0;
      guard <= '0;
    end else begin
      sw_s0 <= sw_data;
      sw_s1 <= sw_s0;
      data_out <= enq_acc ? sw_s1 : data_out;
      enqueue_out <= go && enq_req && !full;
      dequeue_out <= go && !enq_req && !empty;
      drop_out <= go && (enq_req ? full : empty);
      enq_pend <= enq_req && !go;
      deq_pend <= deq_req && !(go && !enq_req);
      guard <= pulse ? GW'(GUARD_CYCLES) : busy_out ? guard - 1'b1 : guard;
    end
endmodule

// File: tb/tb_fila_entrada.sv
// tb_fila_entrada: scoreboard bench for fila_entrada with DEBOUNCE_CYCLES=4, GUARD_CYCLES=2
module tb_fila_entrada;
  logic clk_10KHz = 1'b0, reset = 1'b0, btn_enq = 1'b0, btn_deq = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic [3:0] len_in = 4'd0;
  logic enqueue_out, dequeue_out, busy_out, drop_out;
  logic [7:0] data_out;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int kind; logic [7:0] data; int at;} ev_t;
  ev_t q[$];
  fila_entrada #(.DEBOUNCE_CYCLES(4), .GUARD_CYCLES(2)) dut (
    .clk_10KHz(clk_10KHz), .reset(reset), .btn_enq(btn_enq), .btn_deq(btn_deq),
    .sw_data(sw_data), .len_in(len_in), .enqueue_out(enqueue_out), .dequeue_out(dequeue_out),
    .data_out(data_out), .busy_out(busy_out), .drop_out(drop_out));
  always #5 clk_10KHz = ~clk_10KHz;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic nclk(input int n);
    repeat (n) @(negedge clk_10KHz);
  endtask
  function automatic void push(input int k, input logic [7:0] d, input int at);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.at = at;
    q.push_back(e);
  endfunction
  // monitor: kind 0 = enqueue, 1 = dequeue, 2 = drop
  initial forever begin
    @(posedge clk_10KHz);
    cyc++;
    #1;
    if (enqueue_out || dequeue_out || drop_out) begin
      ev_t e;
      int k;
      k = enqueue_out ? 0 : dequeue_out ? 1 : 2;
      chk("onehot", $countones({enqueue_out, dequeue_out, drop_out}), 1);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected pulse kind=%0d at cycle %0d", k, cyc);
      end else begin
        e = q.pop_front();
        chk("kind", k, e.kind);
        chk("cycle", cyc, e.at);
        if (e.kind == 0) chk("data", data_out, e.data);
      end
    end
  end
  initial begin
    nclk(3);
    chk("rst_enq", enqueue_out, 0);
    chk("rst_deq", dequeue_out, 0);
    chk("rst_drop", drop_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_data", data_out, 0);
    reset = 1'b1;
    nclk(2);
    // held enqueue press: one pulse, then two busy cycles
    sw_data = 8'hA5;
    btn_enq = 1'b1;
    push(0, 8'hA5, cyc + 8);
    nclk(9);
    chk("t1_enq_low", enqueue_out, 0);
    chk("t1_busy1", busy_out, 1);
    nclk(1);
    chk("t1_busy2", busy_out, 1);
    nclk(1);
    chk("t1_busy_end", busy_out, 0);
    nclk(9);
    btn_enq = 1'b0;
    nclk(12);
    // glitches of 1..3 cycles never reach acceptance
    for (int i = 0; i < 10; i++) begin
      btn_enq = 1'b1;
      nclk(i % 3 + 1);
      btn_enq = 1'b0;
      nclk(i % 2 + 1);
    end
    nclk(12);
    // full queue drops enqueue, empty queue drops dequeue
    len_in = 4'd8;
    sw_data = 8'h3C;
    btn_enq = 1'b1;
    push(2, 8'h00, cyc + 8);
    nclk(10);
    btn_enq = 1'b0;
    nclk(12);
    len_in = 4'd0;
    btn_deq = 1'b1;
    push(2, 8'h00, cyc + 8);
    nclk(10);
    btn_deq = 1'b0;
    nclk(12);
    // simultaneous presses: enqueue first, dequeue three cycles later
    len_in = 4'd3;
    sw_data = 8'h77;
    btn_enq = 1'b1;
    btn_deq = 1'b1;
    push(0, 8'h77, cyc + 8);
    push(1, 8'h00, cyc + 11);
    nclk(14);
    btn_enq = 1'b0;
    btn_deq = 1'b0;
    nclk(12);
    // reset during PRESS_WAIT with count 3, released with button still high
    sw_data = 8'h5A;
    btn_enq = 1'b1;
    nclk(5);
    reset = 1'b0;
    nclk(1);
    chk("mid_rst_enq", enqueue_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_data", data_out, 0);
    nclk(2);
    reset = 1'b1;
    push(0, 8'h5A, cyc + 8);
    nclk(14);
    btn_enq = 1'b0;
    nclk(12);
    // short release does not re-arm the button
    len_in = 4'd2;
    sw_data = 8'hC3;
    btn_enq = 1'b1;
    push(0, 8'hC3, cyc + 8);
    nclk(50);
    btn_enq = 1'b0;
    nclk(2);
    btn_enq = 1'b1;
    nclk(20);
    btn_enq = 1'b0;
    nclk(12);
    chk("pending_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fila_entrada.md
# fila_entrada

Input-conditioning stage directly upstream of the 8-entry queue. Synchronises and debounces the enqueue and dequeue push-buttons, latches the 8-bit switch value on a recognised enqueue press, and emits single-cycle `enqueue_out`/`dequeue_out` pulses that feed the queue's `enqueue_in`/`dequeue_in`. Requests are gated against the queue's reported length and spaced by a guard interval that covers the queue's two-cycle dequeue and its one-cycle-late length report.

## Interface
- `DEBOUNCE_CYCLES`, default 100: consecutive stable synchronised samples required to accept a press or a release (10 ms at 10 kHz).
- `GUARD_CYCLES`, default 2: cycles after any issued pulse during which no new pulse is issued.
- `clk_10KHz`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `btn_enq`  in  1  raw enqueue button, asynchronous, active-high.
- `btn_deq`  in  1  raw dequeue button, asynchronous, active-high.
- `sw_data`  in  8  raw switch value to enqueue.
- `len_in`  in  4  queue occupancy (0..8), driven by the queue's `len_out`.
- `enqueue_out`  out  1  one-cycle enqueue request to the queue.
- `dequeue_out`  out  1  one-cycle dequeue request to the queue.
- `data_out`  out  8  latched switch value, valid while `enqueue_out` = 1 and held until the next accepted enqueue press.
- `busy_out`  out  1  high while the guard interval is running.
- `drop_out`  out  1  one-cycle pulse when a pending request is discarded (queue full/empty).

## Operation
- Each button passes through a 2-flop synchroniser, then its own debounce FSM: IDLE -> PRESS_WAIT (sync = 1; counter increments; sync = 0 returns to IDLE and clears the counter) -> on count = DEBOUNCE_CYCLES: ACCEPT (1 cycle, sets pending flag) -> HELD (waits for sync = 0) -> RELEASE_WAIT (sync = 0 counted; sync = 1 returns to HELD) -> on count = DEBOUNCE_CYCLES: IDLE.
- A held button produces exactly one request. A new request requires a full debounced release first.
- On the ACCEPT cycle of the enqueue FSM, the synchronised `sw_data` is latched into `data_out`. A second enqueue acceptance while enqueue is still pending overwrites `data_out` and does not create a second request.
- Issue logic runs when `busy_out` = 0 and at least one request is pending:
  - Enqueue pending has priority. If `len_in` < 8: pulse `enqueue_out`. If `len_in` = 8: clear the request and pulse `drop_out`.
  - Otherwise, with dequeue pending: if `len_in` > 0, pulse `dequeue_out`; if `len_in` = 0, clear the request and pulse `drop_out`.
  - Only one of `enqueue_out`, `dequeue_out`, `drop_out` is high in any cycle. A losing request stays pending.
- Any issued pulse (enqueue, dequeue or drop) loads the guard counter with GUARD_CYCLES. `busy_out` stays high until the counter reaches 0.
- The guard counter width is sized for GUARD_CYCLES. The debounce counter width is sized for DEBOUNCE_CYCLES and saturates.

## Timing
- Reset (`reset` = 0, asynchronous): all outputs 0, synchronisers 0, both FSMs IDLE, counters 0, pending flags cleared. Reset asserted mid-debounce or mid-guard aborts the operation; no pulse follows reset release.
- Latency: with `btn_enq` high and stable from before edge 0 and the block idle, ACCEPT occurs after edge DEBOUNCE_CYCLES+2. `enqueue_out` is high for the one cycle following edge DEBOUNCE_CYCLES+3.
- `busy_out` rises on the same edge that ends the pulse and stays high for GUARD_CYCLES cycles.
- Bounces shorter than DEBOUNCE_CYCLES synchronised cycles produce no request.
- Simultaneous acceptance of both buttons: enqueue issues first. Dequeue issues GUARD_CYCLES+1 cycles later, re-checked against `len_in` at that time.

## Test plan
- DEBOUNCE_CYCLES=4, GUARD_CYCLES=2, `len_in`=0, `sw_data`=8'hA5, `btn_enq` held high 20 cycles -> exactly one `enqueue_out` pulse 7 cycles after the press, with `data_out`=8'hA5 during it. Then `busy_out` high for 2 cycles.
- `btn_enq` toggled 1-3 cycle glitches for 30 cycles, then released -> no `enqueue_out`, no `drop_out`.
- `len_in`=8, enqueue press -> `drop_out` pulse, no `enqueue_out`. `len_in`=0, dequeue press -> `drop_out` pulse, no `dequeue_out`.
- Both buttons pressed on the same cycle, `len_in`=3 -> `enqueue_out` first. `dequeue_out` follows exactly 3 cycles later.
- `reset` driven low while in PRESS_WAIT with count 3, then released with button still high -> all outputs 0 during reset. The press is re-debounced from zero and one pulse occurs 7 cycles after reset release.
- Button held 50 cycles, released for 2 cycles, pressed again -> second press is ignored until a full 4-cycle release has been debounced. Total pulses = 1.
